// File: rtl/breg_pair_sched_if.sv
// breg_pair_sched_if: two-requester operand-beat handshake bundle
interface breg_pair_sched_if;
    logic        s0_valid, s1_valid;
    logic [17:0] s0_data, s1_data;
    logic        s0_ready, s1_ready;
    modport master (output s0_valid, s1_valid, s0_data, s1_data, input s0_ready, s1_ready);
    modport slave  (input s0_valid, s1_valid, s0_data, s1_data, output s0_ready, s1_ready);
endinterface

// File: rtl/breg_pair_sched.sv
// breg_pair_sched: round-robin operand-pair scheduler for a BREG=2 datapath
// Optional post-pair datapath clear cycle enabled by BREG_PAIR_SCHED_FLUSH_EN.
module breg_pair_sched (
    input  logic               clk,
    input  logic               RSTN,
    breg_pair_sched_if.slave   req,
    output logic [17:0]        B,
    output logic               CEB1,
    output logic               CEB2,
    output logic               INMODE,
    output logic               RSTB,
    output logic               mult_valid,
    output logic               mult_src,
    output logic               busy
);
`ifdef BREG_PAIR_SCHED_FLUSH_EN
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ISSUE_A, ISSUE_B, FLUSH} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ISSUE_A, ISSUE_B} state_t;
`endif
    state_t state, nxt;
    logic   grant, grant_nxt, last, last_nxt, load, fire;

    // last resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        nxt       = state;
        grant_nxt = grant;
        last_nxt  = last;
        load      = state == LOAD_A || state == LOAD_B;
        fire      = load && (grant ? req.s1_valid : req.s0_valid);
        case (state)
            IDLE: if (req.s0_valid || req.s1_valid) begin
                nxt       = LOAD_A;
                grant_nxt = (req.s0_valid && req.s1_valid) ? ~last : req.s1_valid;
            end
            LOAD_A:  nxt = fire ? LOAD_B : LOAD_A;
            LOAD_B:  nxt = fire ? ISSUE_A : LOAD_B;
            ISSUE_A: nxt = ISSUE_B;
            ISSUE_B: begin
                last_nxt = grant;
`ifdef BREG_PAIR_SCHED_FLUSH_EN
                nxt      = FLUSH;
`else
                nxt      = IDLE;
`endif
            end
            default: nxt = IDLE;
        endcase
    end

    assign req.s0_ready = load && !grant;
    assign req.s1_ready = load && grant;
    assign mult_valid   = state == ISSUE_A || state == ISSUE_B;
    assign B            = (load || mult_valid) ? (grant ? req.s1_data : req.s0_data) : '0;
    assign CEB1         = fire;
    assign CEB2         = fire && state == LOAD_B;
    assign INMODE       = state == ISSUE_B;
    assign mult_src     = mult_valid && grant;
    assign busy         = state != IDLE;
`ifdef BREG_PAIR_SCHED_FLUSH_EN
    assign RSTB         = state == FLUSH;
`else
    assign RSTB         = 1'b0;
`endif
endmodule

// File: tb/tb_breg_pair_sched.sv
// tb_breg_pair_sched: vector table plus scoreboard against a BREG=2 datapath model
module tb_breg_pair_sched;
`ifdef BREG_PAIR_SCHED_FLUSH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    logic clk = 1'b0, RSTN = 1'b0;
    logic [17:0] B;
    logic CEB1, CEB2, INMODE, RSTB, mult_valid, mult_src, busy;
    breg_pair_sched_if bus ();

    breg_pair_sched dut (.clk(clk), .RSTN(RSTN), .req(bus), .B(B), .CEB1(CEB1), .CEB2(CEB2),
                         .INMODE(INMODE), .RSTB(RSTB), .mult_valid(mult_valid),
                         .mult_src(mult_src), .busy(busy));

    always #5 clk = ~clk;

    typedef struct {
        logic        v0, v1;
        logic [17:0] d0, d1;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [18:0] q[$];
    logic [17:0] st1 = '0, st2 = '0;
    int nvec = 0, nerr = 0, pairs = 0, rstb_hits = 0;

    function automatic logic [31:0] mk(logic s0r, s1r, logic [17:0] b, logic c1, c2, im, rb, mv, src, bz);
        return {5'b0, s0r, s1r, b, c1, c2, im, rb, mv, src, bz};
    endfunction

    function automatic logic [31:0] outs();
        return mk(bus.s0_ready, bus.s1_ready, B, CEB1, CEB2, INMODE, RSTB, mult_valid, mult_src, busy);
    endfunction

    function automatic vec_t row(logic v0, v1, logic [17:0] d0, d1, logic [31:0] e);
        vec_t r;
        r.v0 = v0; r.v1 = v1; r.d0 = d0; r.d1 = d1; r.exp = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v0, v1, input logic [17:0] d0, d1);
        bus.s0_valid = v0; bus.s1_valid = v1; bus.s0_data = d0; bus.s1_data = d1;
    endtask

    // sampled just before the rising edge: push fired beats, pop on issue, clock the datapath model
    task automatic sb_step();
        logic [18:0] e;
        if (bus.s0_ready && bus.s0_valid) q.push_back({1'b0, B});
        if (bus.s1_ready && bus.s1_valid) q.push_back({1'b1, B});
        if (mult_valid) begin
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = q.pop_front();
                chk("sb_operand", {13'b0, mult_src, INMODE ? st1 : st2}, {13'b0, e});
            end
            if (INMODE) pairs++;
        end
        if (RSTB) rstb_hits++;
        if (RSTB) begin
            st1 = '0; st2 = '0;
        end else begin
            if (CEB2) st2 = st1;
            if (CEB1) st1 = B;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        RSTN = 1'b0;
        q.delete(); st1 = '0; st2 = '0;
        @(negedge clk);
        RSTN = 1'b1;
    endtask

    initial begin
        int k, bad;
        bit found;
        tbl.push_back(row(1, 0, 18'h00012, 18'h2AAAA, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(1, 0, 18'h00012, 18'h2AAAA, mk(1, 0, 18'h00012, 1, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(row(1, 0, 18'h00034, 18'h2AAAA, mk(1, 0, 18'h00034, 1, 1, 0, 0, 0, 0, 1)));
        tbl.push_back(row(0, 0, 18'h00034, 18'h2AAAA, mk(0, 0, 18'h00034, 0, 0, 0, 0, 1, 0, 1)));
        tbl.push_back(row(0, 0, 18'h00034, 18'h2AAAA, mk(0, 0, 18'h00034, 0, 0, 1, 0, 1, 0, 1)));
        if (FL) tbl.push_back(row(0, 0, 18'h00034, 18'h2AAAA, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1)));
        tbl.push_back(row(0, 0, 18'h00034, 18'h2AAAA, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(0, 1, 18'h3FFFF, 18'h00055, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(row(0, 1, 18'h3FFFF, 18'h00055, mk(0, 1, 18'h00055, 1, 0, 0, 0, 0, 0, 1)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(row(0, 0, 18'h3FFFF, 18'h00066, mk(0, 1, 18'h00066, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(row(0, 1, 18'h3FFFF, 18'h00066, mk(0, 1, 18'h00066, 1, 1, 0, 0, 0, 0, 1)));
        tbl.push_back(row(0, 0, 18'h3FFFF, 18'h00066, mk(0, 0, 18'h00066, 0, 0, 0, 0, 1, 1, 1)));
        tbl.push_back(row(0, 0, 18'h3FFFF, 18'h00066, mk(0, 0, 18'h00066, 0, 0, 1, 0, 1, 1, 1)));
        if (FL) tbl.push_back(row(0, 0, 18'h3FFFF, 18'h00066, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1)));
        tbl.push_back(row(0, 0, 18'h3FFFF, 18'h00066, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

        drive(1, 1, 18'h1, 18'h2);
        repeat (2) @(negedge clk);
        #1 chk("reset_outs", outs(), 0);
        @(negedge clk);
        RSTN = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1);
            #1 chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
            sb_step();
            @(negedge clk);
        end

        // contention from reset: grants must alternate 0,1,0,1
        drive(0, 0, 18'h00111, 18'h00222);
        reset_pulse();
        drive(1, 1, 18'h00111, 18'h00222);
        k = 0; bad = 0;
        for (int c = 0; c < 80 && k < 4; c++) begin
            #1;
            if (k[0] ? bus.s0_ready : bus.s1_ready) bad++;
            if (mult_valid && !INMODE) chk($sformatf("cont_grant%0d", k), {31'b0, mult_src}, k % 2);
            if (mult_valid && INMODE) k++;
            sb_step();
            @(negedge clk);
        end
        chk("cont_pairs", k, 4);
        chk("cont_foreign_ready", bad, 0);

        // abort a requester-1 pair in LOAD_B; requester 0 must win next
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            #1;
            if (bus.s1_ready && CEB2) found = 1'b1;
            else begin
                sb_step();
                @(negedge clk);
            end
        end
        chk("rst_found", {31'b0, found}, 1);
        RSTN = 1'b0;
        q.delete(); st1 = '0; st2 = '0;
        #1 chk("rst_mid_outs", outs(), 0);
        @(negedge clk);
        RSTN = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            #1;
            if (mult_valid && !INMODE) begin
                chk("rst_next_grant", {31'b0, mult_src}, 0);
                found = 1'b1;
            end
            sb_step();
            @(negedge clk);
        end
        chk("rst_next_seen", {31'b0, found}, 1);
        drive(0, 0, 18'h0, 18'h0);
        for (int c = 0; c < 8; c++) begin
            #1 sb_step();
            @(negedge clk);
        end
        chk("final_idle", outs(), 0);
        chk("sb_drained", q.size(), 0);
        chk("rstb_count", rstb_hits, FL ? pairs : 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/breg_pair_sched.md
BREG_PAIR_SCHED -- requirements
Module: breg_pair_sched

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, RSTN.
REQ-002 clk  input  1  rising-edge clock shared with the dual B-register datapath.
REQ-003 RSTN  input  1  asynchronous, active-low reset of all block state.
REQ-004 s0_valid / s1_valid  input  1  requester 0/1 offers an operand beat.
REQ-005 s0_data / s1_data  input  18  requester 0/1 operand beat.
REQ-006 s0_ready / s1_ready  output  1  block accepts requester 0/1 beat this cycle.
REQ-007 B  output  18  operand to the datapath B input.
REQ-008 CEB1, CEB2  output  1  clock enables for datapath stage 1/2 (datapath built with BREG=2).
REQ-009 INMODE  output  1  multiplier operand select: 0 = stage-2 value, 1 = stage-1 value.
REQ-010 RSTB  output  1  synchronous active-high clear to the datapath.
REQ-011 mult_valid  output  1  multiplier operand is valid this cycle.
REQ-012 mult_src  output  1  requester that owns the current multiplier operand.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 A transaction SHALL be one operand pair (beat a, then beat b) from one requester; each beat completes when sN_valid and sN_ready are both high at a rising edge (a "fire").
REQ-015 States SHALL be IDLE, LOAD_A, LOAD_B, ISSUE_A and ISSUE_B, plus FLUSH when the macro in REQ-028 is defined.
REQ-016 IDLE: if any sN_valid is high, the block SHALL latch the grant and go to LOAD_A on the next edge.
REQ-017 Arbitration is round-robin: with both valid, grant goes to the requester that was not granted last; with one valid, that requester wins.
REQ-018 The grant SHALL hold unchanged from LOAD_A through ISSUE_B.
REQ-019 sN_ready SHALL be high only in LOAD_A/LOAD_B and only for the granted N; the ungranted ready stays 0.
REQ-020 B SHALL equal the granted sN_data combinationally and is 0 when no requester is granted.
REQ-021 LOAD_A: CEB1 = fire, CEB2 = 0. On fire, go to LOAD_B; otherwise hold with no timeout.
REQ-022 LOAD_B: CEB1 = CEB2 = fire. On fire, stage 2 captures beat a and stage 1 captures beat b; go to ISSUE_A.
REQ-023 ISSUE_A: INMODE = 0 and mult_valid = 1, so the multiplier sees a; next state is ISSUE_B.
REQ-024 ISSUE_B: INMODE = 1 and mult_valid = 1, so the multiplier sees b; record the grant as last-granted; next state is IDLE (or FLUSH per REQ-028).
REQ-025 mult_src SHALL equal the grant whenever mult_valid = 1 and SHALL be 0 otherwise. CEB1, CEB2, INMODE and RSTB SHALL be 0 in any state not listed as driving them.
REQ-026 Pair latency, with valid held high: the a-fire is 1 cycle after request detection in IDLE; the first mult_valid is 2 cycles after the a-fire; the next IDLE arbitration is 4 cycles after the a-fire (5 cycles with FLUSH).

Reset
REQ-027 While RSTN = 0 the block SHALL be in IDLE with last-granted = 1 (so requester 0 wins first), and all outputs 0. Reset asserted mid-transaction SHALL abort it and discard any accepted beat; the requester must resend the whole pair.

Configuration
REQ-028 Macro BREG_PAIR_SCHED_FLUSH_EN defined: ISSUE_B SHALL go to FLUSH, which drives RSTB = 1 for exactly one cycle (mult_valid = 0) and then goes to IDLE.
REQ-029 Macro not defined: the FLUSH state SHALL not exist, RSTB SHALL be constant 0, and ISSUE_B SHALL go directly to IDLE.

Verification
REQ-030 Single pair: s0 sends 0x00012 then 0x00034 with valid held high. Required: s0_ready high in LOAD_A/LOAD_B; CEB2 high only on the second beat; ISSUE_A has INMODE=0; ISSUE_B has INMODE=1; mult_src=0 in both.
REQ-031 Contention: s0 and s1 valid continuously from reset. Required: grant order 0,1,0,1; s1_ready never high during a requester-0 pair.
REQ-032 Stall: s1 drops valid for 3 cycles between beats a and b. Required: block holds LOAD_B, CEB1=CEB2=0 for those 3 cycles, and the pair completes normally once valid returns.
REQ-033 Reset mid-pair: RSTN pulsed low in LOAD_B. Required: state IDLE and all outputs 0 immediately; the next grant goes to requester 0.
REQ-034 Flush (macro defined): after ISSUE_B, RSTB=1 for exactly one cycle before busy falls. Macro undefined: RSTB stays 0 for the whole run.
